// File: rtl/ccff_loader_pkg.sv
// ---------------------------------------------------------------------------
// ccff_loader_pkg
// Shared types and size helpers for the configuration-chain bitstream loader.
//   state_e   : loader FSM states (IDLE / RUN / DONE)
//   mode_e    : pass type latched with start (LOAD / VERIFY)
//   cnt_w     : width of the bit/word counters for a given chain length
//   nwords    : host words needed to cover the chain
//   tail_bits : bits of the final word actually used (full word if exact fit)
// ---------------------------------------------------------------------------
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        LOAD   = 1'b0,
        VERIFY = 1'b1
    } mode_e;

    // Wide enough to hold CHAIN_LEN itself so the counters never wrap in a pass.
    function automatic int cnt_w(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

    function automatic int nwords(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    function automatic int tail_bits(input int chain_len, input int word_w);
        return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader_if
// Host word stream into the loader (valid/ready handshake).
//   s_data  : bitstream word, bit0 shifted into the chain first
//   s_valid : s_data valid
//   s_ready : loader takes the word on a cycle with s_valid & s_ready
// Modports: master = programming host, slave = loader.
// ---------------------------------------------------------------------------
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/ccff_word_serializer.sv
// ---------------------------------------------------------------------------
// ccff_word_serializer
// One-word skid buffer (holding reg) in front of a shift reg that feeds the
// chain one bit per shift. The final word of a pass is trimmed to TAIL_BITS.
//   clk, rst_n : clock, async active-low reset
//   clear      : drop both buffers (idle / abort)
//   load       : take load_data into the holding reg (only when hold_empty)
//   last       : load_data is the final word of the pass
//   shift      : consume the current bit this cycle
//   hold_empty : holding reg can take a word
//   bit_valid  : shift reg holds at least one unsent bit
//   bit_out    : current bit (LSB of shift reg)
// ---------------------------------------------------------------------------
module ccff_word_serializer #(
    parameter int WORD_W    = 8,
    parameter int TAIL_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              last,
    input  logic [WORD_W-1:0] load_data,
    input  logic              shift,
    output logic              hold_empty,
    output logic              bit_valid,
    output logic              bit_out
);

    localparam int SB_W = $clog2(WORD_W + 1);
    localparam logic [SB_W-1:0]   FULL_BITS = SB_W'(WORD_W);
    localparam logic [SB_W-1:0]   TAIL_CNT  = SB_W'(TAIL_BITS);
    localparam logic [WORD_W-1:0] TAIL_MASK = {WORD_W{1'b1}} >> (WORD_W - TAIL_BITS);

    // A buffer is "full" when its remaining-bit count is non-zero.
    logic [WORD_W-1:0] hold_data, sh_data;
    logic [SB_W-1:0]   hold_bits, sh_bits;
    logic              shift_now, refill;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        shift_now = 1'b0;
        refill    = 1'b0;
        shift_now = shift && (sh_bits != '0);
        // Refill in the same cycle the last bit leaves: no bubble between words.
        refill    = (hold_bits != '0) &&
                    ((sh_bits == '0) || (shift_now && (sh_bits == SB_W'(1))));
    end

    assign hold_empty = (hold_bits == '0);
    assign bit_valid  = (sh_bits != '0);
    assign bit_out    = sh_data[0];

    // NOTE: these are a handful of flops, not a memory array, so resetting the
    // data as well as the counts is cheap and keeps outputs deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data <= '0;
            hold_bits <= '0;
            sh_data   <= '0;
            sh_bits   <= '0;
        end else if (clear) begin
            hold_bits <= '0;
            sh_bits   <= '0;
        end else begin
            // load only happens with the holding reg empty, refill only with it
            // full, so the two never coincide.
            if (load) begin
                hold_data <= last ? (load_data & TAIL_MASK) : load_data;
                hold_bits <= last ? TAIL_CNT : FULL_BITS;
            end else if (refill) begin
                hold_bits <= '0;
            end

            if (refill) begin
                sh_data <= hold_data;
                sh_bits <= hold_bits;
            end else if (shift_now) begin
                sh_data <= sh_data >> 1;
                sh_bits <= sh_bits - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
// Streams host words onto ccff_head of the tile configuration chain and gates
// the chain shift. A VERIFY pass re-streams the image and compares ccff_tail
// against it bit by bit; when the image matches, chain contents are unchanged.
//   prog_clk, pReset_n : programming clock (shared with chain), async reset
//   start, mode        : begin a pass (mode 0=LOAD, 1=VERIFY), ignored if busy
//   abort              : level, returns to IDLE on the next edge, no done
//   host               : word stream (slave modport)
//   ccff_head          : serial bit into the chain
//   ccff_shift_en      : chain captures ccff_head on this edge
//   ccff_tail          : serial bit out of the chain end
//   busy, done         : pass in progress / 1-cycle completion pulse
//   err_cnt            : saturating verify mismatch count
// ---------------------------------------------------------------------------
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8,
    parameter int ERR_W     = 16
) (
    input  logic                prog_clk,
    input  logic                pReset_n,
    input  logic                start,
    input  logic                mode,
    input  logic                abort,
    ccff_chain_loader_if.slave  host,
    output logic                ccff_head,
    output logic                ccff_shift_en,
    input  logic                ccff_tail,
    output logic                busy,
    output logic                done,
    output logic [ERR_W-1:0]    err_cnt
);

    localparam int CNT_W  = cnt_w(CHAIN_LEN);
    localparam int NWORDS = nwords(CHAIN_LEN, WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0] WORD_LIM  = CNT_W'(NWORDS);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    state_e           state_q;
    mode_e            mode_q;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] word_cnt;

    logic running;
    logic word_accept;
    logic hold_empty;
    logic bit_valid;
    logic head_bit;

    assign running       = (state_q == RUN);
    assign host.s_ready  = running && hold_empty && (word_cnt < WORD_LIM);
    assign word_accept   = host.s_valid && host.s_ready;
    assign ccff_shift_en = running && bit_valid;
    assign ccff_head     = ccff_shift_en ? head_bit : 1'b0;

    ccff_word_serializer #(
        .WORD_W    (WORD_W),
        .TAIL_BITS (tail_bits(CHAIN_LEN, WORD_W))
    ) u_ser (
        .clk        (prog_clk),
        .rst_n      (pReset_n),
        .clear      (!running || abort),
        .load       (word_accept),
        .last       (word_cnt == LAST_WORD),
        .load_data  (host.s_data),
        .shift      (ccff_shift_en),
        .hold_empty (hold_empty),
        .bit_valid  (bit_valid),
        .bit_out    (head_bit)
    );

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, exactly like the chain flops themselves.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q  <= IDLE;
            mode_q   <= LOAD;
            bit_cnt  <= '0;
            word_cnt <= '0;
            err_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    // abort takes priority over a coincident start.
                    if (start && !abort) begin
                        state_q  <= RUN;
                        mode_q   <= mode_e'(mode);
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                        err_cnt  <= '0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    // The edge that aborts still clocks the chain if shift_en
                    // was high, so that compare is counted too.
                    if (ccff_shift_en && (mode_q == VERIFY) &&
                        (ccff_tail != ccff_head) && (err_cnt != ERR_MAX)) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                    if (abort) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        if (word_accept) begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                        if (ccff_shift_en) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                state_q <= DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_chain_loader
// Directed bench for ccff_chain_loader with a 20-flop chain model
// (CHAIN_LEN=20, WORD_W=8, ERR_W=2). The chain model keeps the first
// shifted bit at chain[0] after a full pass, so a loaded image of words
// w0,w1,w2 reads back as {w2[3:0], w1, w0}.
// ---------------------------------------------------------------------------
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 20;
    localparam int WORD_W    = 8;
    localparam int ERR_W     = 2;

    logic             prog_clk = 1'b0;
    logic             pReset_n;
    logic             start;
    logic             mode;
    logic             abort;
    logic             ccff_head;
    logic             ccff_shift_en;
    logic             ccff_tail;
    logic             busy;
    logic             done;
    logic [ERR_W-1:0] err_cnt;

    logic [CHAIN_LEN-1:0] chain = '0;

    int vectors     = 0;
    int miscompares = 0;

    ccff_chain_loader_if #(.WORD_W(WORD_W)) host ();

    ccff_chain_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W),
        .ERR_W     (ERR_W)
    ) dut (
        .prog_clk      (prog_clk),
        .pReset_n      (pReset_n),
        .start         (start),
        .mode          (mode),
        .abort         (abort),
        .host          (host),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .err_cnt       (err_cnt)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: captures ccff_head on shift edges, tail is the far end.
    always @(posedge prog_clk) begin
        if (ccff_shift_en) chain <= {ccff_head, chain[CHAIN_LEN-1:1]};
    end
    assign ccff_tail = chain[0];

    // Drives one pass and returns what it observed. Runs on negedges.
    //   stall_cycles : s_valid low for this many cycles after word1 is taken
    //   abort_at     : assert abort once this many shift cycles are seen (-1 off)
    //   restart_at   : loop iteration at which to pulse start/mode=1 (-1 off)
    task automatic run_pass(input logic m, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input int stall_cycles,
                            input int abort_at, input int restart_at,
                            output int shifts, output int span, output int dones);
        logic [7:0] words [3];
        int idx, stall, first, last, it;
        bit fin, aborted;
        words   = '{w0, w1, w2};
        shifts  = 0; dones = 0; first = -1; last = -1;
        idx     = 0; stall = 0; it = 0; fin = 1'b0; aborted = 1'b0;
        @(negedge prog_clk);
        start = 1'b1; mode = m;
        @(negedge prog_clk);
        while (!fin && it < 300) begin
            if (ccff_shift_en) begin
                shifts++;
                if (first < 0) first = it;
                last = it;
            end
            if (done) begin
                dones++;
                fin = 1'b1;
            end
            start = (it == restart_at);
            mode  = (it == restart_at);
            if (aborted) begin
                abort = 1'b0;
                fin   = 1'b1;
            end else if (abort_at >= 0 && shifts == abort_at) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end
            if (!fin && idx < 3 && stall == 0) begin
                host.s_valid = 1'b1;
                host.s_data  = words[idx];
                if (host.s_ready) begin
                    idx++;
                    if (idx == 2) stall = stall_cycles;
                end
            end else begin
                host.s_valid = 1'b0;
                host.s_data  = '0;
                if (stall > 0) stall--;
            end
            if (!fin) begin
                @(negedge prog_clk);
                it++;
            end
        end
        start = 1'b0; mode = 1'b0; host.s_valid = 1'b0;
        span = (first < 0) ? 0 : (last - first + 1);
        vectors++;
        if (!fin) begin
            miscompares++;
            $display("FAIL pass_timeout: pass did not finish within %0d cycles", it);
        end
    endtask

    // Watch a few idle cycles after a pass and return how many done pulses appear.
    task automatic watch_idle(input int cycles, output int dones, output int shifts);
        dones = 0; shifts = 0;
        repeat (cycles) begin
            @(negedge prog_clk);
            if (done) dones++;
            if (ccff_shift_en) shifts++;
        end
    endtask

    task automatic test_reset();
        pReset_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
        host.s_valid = 1'b0; host.s_data = '0;
        repeat (3) @(negedge prog_clk);
        vectors++; if (busy !== 1'b0)          begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0)          begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (host.s_ready !== 1'b0)  begin miscompares++; $display("FAIL reset_s_ready: got %b want 0", host.s_ready); end
        vectors++; if (ccff_shift_en !== 1'b0) begin miscompares++; $display("FAIL reset_shift_en: got %b want 0", ccff_shift_en); end
        vectors++; if (ccff_head !== 1'b0)     begin miscompares++; $display("FAIL reset_head: got %b want 0", ccff_head); end
        vectors++; if (err_cnt !== 2'd0)       begin miscompares++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        pReset_n = 1'b1;
        repeat (2) @(negedge prog_clk);
        vectors++; if (host.s_ready !== 1'b0)  begin miscompares++; $display("FAIL idle_s_ready: got %b want 0", host.s_ready); end
    endtask

    task automatic test_load();
        int sh, sp, dn, xdn, xsh;
        run_pass(1'b0, 8'hA5, 8'h3C, 8'h0F, 0, -1, -1, sh, sp, dn);
        vectors++; if (sh !== 20)               begin miscompares++; $display("FAIL load_shifts: got %0d want 20", sh); end
        vectors++; if (sp !== 20)               begin miscompares++; $display("FAIL load_contiguous_span: got %0d want 20", sp); end
        vectors++; if (dn !== 1)                begin miscompares++; $display("FAIL load_done: got %0d want 1", dn); end
        vectors++; if (busy !== 1'b0)           begin miscompares++; $display("FAIL load_busy_with_done: got %b want 0", busy); end
        vectors++; if (err_cnt !== 2'd0)        begin miscompares++; $display("FAIL load_err_cnt: got %0d want 0", err_cnt); end
        vectors++; if (chain !== 20'hF3CA5)     begin miscompares++; $display("FAIL load_chain: got %h want F3CA5", chain); end
        watch_idle(3, xdn, xsh);
        vectors++; if (xdn !== 0)               begin miscompares++; $display("FAIL load_extra_done: got %0d want 0", xdn); end
        vectors++; if (xsh !== 0)               begin miscompares++; $display("FAIL load_idle_shift: got %0d want 0", xsh); end
    endtask

    task automatic test_verify_match();
        int sh, sp, dn;
        run_pass(1'b1, 8'hA5, 8'h3C, 8'h0F, 0, -1, -1, sh, sp, dn);
        vectors++; if (err_cnt !== 2'd0)        begin miscompares++; $display("FAIL verify_match_err: got %0d want 0", err_cnt); end
        vectors++; if (sh !== 20)               begin miscompares++; $display("FAIL verify_match_shifts: got %0d want 20", sh); end
        vectors++; if (dn !== 1)                begin miscompares++; $display("FAIL verify_match_done: got %0d want 1", dn); end
        vectors++; if (chain !== 20'hF3CA5)     begin miscompares++; $display("FAIL verify_match_chain: got %h want F3CA5", chain); end
    endtask

    task automatic test_verify_errors();
        int sh, sp, dn, xdn, xsh;
        // word1 bit0 flipped: exactly one mismatch.
        run_pass(1'b1, 8'hA5, 8'h3D, 8'h0F, 0, -1, -1, sh, sp, dn);
        vectors++; if (err_cnt !== 2'd1)        begin miscompares++; $display("FAIL verify_one_bit_err: got %0d want 1", err_cnt); end
        watch_idle(4, xdn, xsh);
        vectors++; if (err_cnt !== 2'd1)        begin miscompares++; $display("FAIL verify_err_held: got %0d want 1", err_cnt); end
        vectors++; if (chain !== 20'hF3DA5)     begin miscompares++; $display("FAIL verify_one_bit_chain: got %h want F3DA5", chain); end
        // Every bit inverted: 20 mismatches saturate a 2-bit counter at 3.
        run_pass(1'b1, 8'h5A, 8'hC2, 8'hF0, 0, -1, -1, sh, sp, dn);
        vectors++; if (err_cnt !== 2'd3)        begin miscompares++; $display("FAIL verify_saturate_err: got %0d want 3", err_cnt); end
        vectors++; if (dn !== 1)                begin miscompares++; $display("FAIL verify_saturate_done: got %0d want 1", dn); end
        vectors++; if (chain !== 20'h0C25A)     begin miscompares++; $display("FAIL verify_saturate_chain: got %h want 0C25A", chain); end
    endtask

    task automatic test_stall();
        int sh, sp, dn;
        // A long host stall after word1 drains both buffers: the chain freezes.
        run_pass(1'b0, 8'hA5, 8'h3C, 8'h0F, 20, -1, -1, sh, sp, dn);
        vectors++; if (sh !== 20)               begin miscompares++; $display("FAIL stall_shifts: got %0d want 20", sh); end
        vectors++; if (!(sp > 20))              begin miscompares++; $display("FAIL stall_gap_span: got %0d want >20", sp); end
        vectors++; if (dn !== 1)                begin miscompares++; $display("FAIL stall_done: got %0d want 1", dn); end
        vectors++; if (chain !== 20'hF3CA5)     begin miscompares++; $display("FAIL stall_chain: got %h want F3CA5", chain); end
    endtask

    task automatic test_abort();
        int sh, sp, dn, xdn, xsh;
        // VERIFY with word0 bit0 flipped, aborted after 10 shifts: err_cnt keeps 1.
        run_pass(1'b1, 8'hA4, 8'h3C, 8'h0F, 0, 10, -1, sh, sp, dn);
        vectors++; if (sh !== 10)               begin miscompares++; $display("FAIL abort_shifts: got %0d want 10", sh); end
        vectors++; if (busy !== 1'b0)           begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
        vectors++; if (host.s_ready !== 1'b0)   begin miscompares++; $display("FAIL abort_s_ready: got %b want 0", host.s_ready); end
        vectors++; if (ccff_shift_en !== 1'b0)  begin miscompares++; $display("FAIL abort_shift_en: got %b want 0", ccff_shift_en); end
        vectors++; if (err_cnt !== 2'd1)        begin miscompares++; $display("FAIL abort_err_partial: got %0d want 1", err_cnt); end
        watch_idle(4, xdn, xsh);
        vectors++; if ((dn + xdn) !== 0)        begin miscompares++; $display("FAIL abort_no_done: got %0d want 0", dn + xdn); end
        vectors++; if (xsh !== 0)               begin miscompares++; $display("FAIL abort_frozen: got %0d want 0", xsh); end
        run_pass(1'b0, 8'hA5, 8'h3C, 8'h0F, 0, -1, -1, sh, sp, dn);
        vectors++; if (sh !== 20)               begin miscompares++; $display("FAIL after_abort_shifts: got %0d want 20", sh); end
        vectors++; if (dn !== 1)                begin miscompares++; $display("FAIL after_abort_done: got %0d want 1", dn); end
        vectors++; if (err_cnt !== 2'd0)        begin miscompares++; $display("FAIL after_abort_err_clear: got %0d want 0", err_cnt); end
        vectors++; if (chain !== 20'hF3CA5)     begin miscompares++; $display("FAIL after_abort_chain: got %h want F3CA5", chain); end
    endtask

    task automatic test_start_while_busy();
        int sh, sp, dn, xdn, xsh;
        // LOAD of an inverted image with a VERIFY start pulsed mid-pass. Were the
        // pulse taken, every compare would mismatch and err_cnt would reach 3.
        run_pass(1'b0, 8'h5A, 8'hC3, 8'hF0, 0, -1, 8, sh, sp, dn);
        vectors++; if (err_cnt !== 2'd0)        begin miscompares++; $display("FAIL busy_start_mode: got err %0d want 0", err_cnt); end
        vectors++; if (sh !== 20)               begin miscompares++; $display("FAIL busy_start_shifts: got %0d want 20", sh); end
        vectors++; if (sp !== 20)               begin miscompares++; $display("FAIL busy_start_span: got %0d want 20", sp); end
        watch_idle(3, xdn, xsh);
        vectors++; if ((dn + xdn) !== 1)        begin miscompares++; $display("FAIL busy_start_done: got %0d want 1", dn + xdn); end
        vectors++; if (chain !== 20'h0C35A)     begin miscompares++; $display("FAIL busy_start_chain: got %h want 0C35A", chain); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_verify_match();
        test_verify_errors();
        test_stall();
        test_abort();
        test_start_while_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
